// File: rtl/key_loader.sv
// Key assembly block: collects WORD_W-bit words MSW-first into a right-aligned
// 128/192/256-bit key selected by key_mode, with restart and illegal-mode flagging.
module key_loader #(
    parameter int WORD_W = 16,
    parameter int KEY_W  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic [1:0]                    key_mode,
    input  logic [WORD_W-1:0]             key_word,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic [KEY_W-1:0]              key,
    output logic [1:0]                    key_len,
    output logic                          key_valid,
    output logic                          busy,
    output logic [$clog2(256/WORD_W):0]   word_cnt,
    output logic                          mode_err
);

    localparam int CNT_W = $clog2(256/WORD_W) + 1;
    localparam logic [CNT_W-1:0] N_128   = CNT_W'(128/WORD_W);
    localparam logic [CNT_W-1:0] N_192   = CNT_W'(192/WORD_W);
    localparam logic [CNT_W-1:0] N_256   = CNT_W'(256/WORD_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [1:0]         len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q;
    logic               err_q, err_d;
    logic               start_legal_s;
    logic [CNT_W-1:0]   n_words_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // Next-state, datapath and flag logic; a legal restart overrides any word.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        err_d         = 1'b0;
        start_legal_s = load_start && (key_mode != 2'b11);
        cnt_inc_s     = cnt_q + CNT_ONE;

        // key_len never latches 2'b11, so the default arm only guards corruption
        case (len_q)
            2'b00:   n_words_s = N_128;
            2'b01:   n_words_s = N_192;
            2'b10:   n_words_s = N_256;
            default: n_words_s = N_256;
        endcase

        if (load_start && (key_mode == 2'b11)) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        if (start_legal_s) begin
            state_d = LOAD;
            key_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            len_d   = key_mode;
        end else begin
            case (state_q)
                LOAD: begin
                    if (word_valid) begin
                        key_d = {key_q[KEY_W-WORD_W-1:0], key_word};
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == n_words_s) begin
                            state_d = DONE;
                            valid_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            len_q   <= 2'b00;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == LOAD);
            err_q   <= err_d;
        end
    end

    assign key        = key_q;
    assign key_len    = len_q;
    assign word_cnt   = cnt_q;
    assign key_valid  = valid_q;
    assign busy       = busy_q;
    assign word_ready = busy_q;
    assign mode_err   = err_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader (WORD_W=16): table-driven key loads with a
// key scoreboard, plus restart, illegal-mode, reset and DONE-hold sequences.
module tb_key_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start;
    logic [1:0]   key_mode;
    logic [15:0]  key_word;
    logic         word_valid;
    logic         word_ready;
    logic [255:0] key;
    logic [1:0]   key_len;
    logic         key_valid;
    logic         busy;
    logic [4:0]   word_cnt;
    logic         mode_err;

    int total = 0;
    int bad   = 0;

    logic [255:0] sb_q[$];
    logic         kv_prev = 1'b0;

    typedef struct {
        logic [1:0]   mode;
        logic [15:0]  base;
        int           gap;
        int           nw;
        logic [255:0] exp_key;
    } vec_t;

    vec_t vecs[4];

    key_loader #(.WORD_W(16), .KEY_W(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .key_mode   (key_mode),
        .key_word   (key_word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .key        (key),
        .key_len    (key_len),
        .key_valid  (key_valid),
        .busy       (busy),
        .word_cnt   (word_cnt),
        .mode_err   (mode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each rising key_valid consumes one expected key.
    always @(negedge clk) begin
        if (key_valid && !kv_prev) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_key act=%h", key);
            end else begin
                check("sb_key", key, sb_q.pop_front());
            end
        end
        kv_prev = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 16'h0001, 0, 8,
                    256'h00010002000300040005000600070008};
        vecs[1] = '{2'b10, 16'h1000, 1, 16,
                    256'h1000100110021003100410051006100710081009100A100B100C100D100E100F};
        vecs[2] = '{2'b01, 16'hA000, 0, 12,
                    256'hA000A001A002A003A004A005A006A007A008A009A00AA00B};
        vecs[3] = '{2'b00, 16'hFFF0, 2, 8,
                    256'hFFF0FFF1FFF2FFF3FFF4FFF5FFF6FFF7};

        rst = 1'b1; load_start = 1'b0; key_mode = 2'b00; key_word = 16'h0000; word_valid = 1'b0;
        tick(); tick();
        check("rst_key", key, 256'd0);
        check("rst_busy", busy, 256'd0);
        check("rst_ready", word_ready, 256'd0);
        check("rst_cnt", word_cnt, 256'd0);
        rst = 1'b0;
        tick();

        // Illegal mode in IDLE
        load_start = 1'b1; key_mode = 2'b11;
        tick();
        load_start = 1'b0;
        check("idle_err_pulse", mode_err, 256'd1);
        check("idle_err_busy", busy, 256'd0);
        check("idle_err_len", key_len, 256'd0);
        check("idle_err_cnt", word_cnt, 256'd0);
        tick();
        check("idle_err_drop", mode_err, 256'd0);

        // Illegal mode during LOAD, then reset after the third word
        load_start = 1'b1; key_mode = 2'b10;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            word_valid = 1'b1; key_word = 16'h4000 + 16'(i);
            tick();
        end
        word_valid = 1'b0; load_start = 1'b1; key_mode = 2'b11;
        tick();
        load_start = 1'b0; key_mode = 2'b00;
        check("load_err_pulse", mode_err, 256'd1);
        check("load_err_cnt", word_cnt, 256'd2);
        check("load_err_key", key, 256'h40004001);
        check("load_err_len", key_len, 256'd2);
        check("load_err_busy", busy, 256'd1);
        word_valid = 1'b1; key_word = 16'h4002;
        tick();
        word_valid = 1'b0;
        check("load_err_drop", mode_err, 256'd0);
        check("third_word_cnt", word_cnt, 256'd3);
        rst = 1'b1;
        #1;
        check("async_rst_key", key, 256'd0);
        check("async_rst_cnt", word_cnt, 256'd0);
        check("async_rst_len", key_len, 256'd0);
        check("async_rst_busy", busy, 256'd0);
        check("async_rst_ready", word_ready, 256'd0);
        check("async_rst_valid", key_valid, 256'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            word_valid = 1'b1; key_word = 16'h5550 + 16'(i);
            tick();
            check("post_rst_cnt", word_cnt, 256'd0);
            check("post_rst_key", key, 256'd0);
        end
        word_valid = 1'b0;

        // Table-driven loads
        for (int v = 0; v < 4; v++) begin
            load_start = 1'b1; key_mode = vecs[v].mode;
            tick();
            load_start = 1'b0;
            check("start_busy", busy, 256'd1);
            check("start_ready", word_ready, 256'd1);
            check("start_key", key, 256'd0);
            check("start_cnt", word_cnt, 256'd0);
            check("start_valid", key_valid, 256'd0);
            check("start_len", key_len, 256'(vecs[v].mode));
            for (int i = 0; i < vecs[v].nw; i++) begin
                for (int g = 0; g < vecs[v].gap; g++) begin
                    word_valid = 1'b0; key_word = 16'hBAD0;
                    tick();
                    check("gap_cnt_hold", word_cnt, 256'(i));
                end
                word_valid = 1'b1; key_word = vecs[v].base + 16'(i);
                if (i == vecs[v].nw - 1) sb_q.push_back(vecs[v].exp_key);
                tick();
                check("acc_valid", key_valid, (i == vecs[v].nw - 1) ? 256'd1 : 256'd0);
            end
            check("done_cnt", word_cnt, 256'(vecs[v].nw));
            check("done_busy", busy, 256'd0);
            // Words offered in DONE must be ignored
            word_valid = 1'b1; key_word = 16'hDEAD;
            tick(); tick();
            word_valid = 1'b0;
            check("done_hold_key", key, vecs[v].exp_key);
            check("done_hold_cnt", word_cnt, 256'(vecs[v].nw));
            check("done_hold_valid", key_valid, 256'd1);
            check("done_hold_ready", word_ready, 256'd0);
        end

        // Restart mid-load with a coincident word
        load_start = 1'b1; key_mode = 2'b01;
        tick();
        load_start = 1'b0;
        check("restart_valid_drop", key_valid, 256'd0);
        for (int i = 0; i < 5; i++) begin
            word_valid = 1'b1; key_word = 16'h2000 + 16'(i);
            tick();
        end
        check("pre_restart_cnt", word_cnt, 256'd5);
        load_start = 1'b1; key_mode = 2'b00; word_valid = 1'b1; key_word = 16'hBEEF;
        tick();
        load_start = 1'b0;
        check("restart_cnt", word_cnt, 256'd0);
        check("restart_key", key, 256'd0);
        check("restart_len", key_len, 256'd0);
        check("restart_busy", busy, 256'd1);
        for (int i = 0; i < 8; i++) begin
            word_valid = 1'b1; key_word = 16'h3000 + 16'(i);
            if (i == 7) sb_q.push_back(256'h30003001300230033004300530063007);
            tick();
        end
        word_valid = 1'b0;
        check("restart_done_valid", key_valid, 256'd1);
        check("restart_done_cnt", word_cnt, 256'd8);
        tick();

        check("sb_drained", 256'(sb_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
